// File: rtl/draw_arbiter_pkg.sv
// draw_arbiter_pkg
// Shared definitions for the draw engine arbiter: coordinate widths,
// requester index assignments, timeout counter width and FSM state encoding.
package draw_arbiter_pkg;

    localparam int X_W   = 9;
    localparam int Y_W   = 8;

    localparam int REQ_RELEASE = 0;
    localparam int REQ_PULL    = 1;
    localparam int REQ_LINE    = 2;
    localparam int REQ_OBJ     = 3;

    // Wide enough for the largest supported timeout (8191).
    localparam int CNT_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_BUSY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/draw_arbiter_rr_select.sv
// rr_select
// Combinational round-robin selector. Finds the first set bit of req,
// searching upward from last+1 and wrapping modulo N_REQ.
// Ports:
//   req   in  N_REQ  request vector
//   last  in  IDX_W  index of the most recently serviced requester
//   valid out 1      any request present
//   idx   out IDX_W  winning requester index (0 when valid is low)
module rr_select #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot;

    // Rotate so that bit 0 of rot corresponds to requester last+1; the
    // lowest set bit of rot is then the winner, offset back by last+1.
    always_comb begin
        req_dbl = {req, req};
        rot     = N_REQ'(req_dbl >> (int'(last) + 1));
        valid   = |req;
        idx     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = IDX_W'((int'(last) + 1 + i) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// draw_arbiter
// Round-robin arbiter sharing one draw engine among N_REQ control FSMs
// (0 release hook, 1 pull-back hook, 2 black line, 3 object renderer).
// The winner's coordinates and erase flag are latched at grant time and
// held until the service ends, so requesters may change them freely.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req               level requests, held until the matching done bit
//   req_erase/x/y     per-requester draw parameters (packed)
//   grant             one-hot, LOAD through DONE
//   done              one-cycle completion pulse to the serviced requester
//   busy              high outside IDLE
//   timeout_err       one-cycle pulse with done when the service was aborted
//   draw_start        engine start, high for the whole of BUSY
//   draw_erase/x/y    latched parameters presented to the engine
//   draw_object_done  engine completion, only looked at in BUSY
//
// state | meaning
// IDLE  | waiting for any request; winner latched on exit
// LOAD  | grant and coordinates presented, engine not yet started
// BUSY  | engine running; leaves on engine done or timeout
// DONE  | done (and timeout_err if aborted) pulse; last winner recorded
module draw_arbiter
    import draw_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ-1:0]     req_erase,
    input  logic [X_W*N_REQ-1:0] req_x,
    input  logic [Y_W*N_REQ-1:0] req_y,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 draw_start,
    output logic                 draw_erase,
    output logic [X_W-1:0]       draw_x,
    output logic [Y_W-1:0]       draw_y,
    input  logic                 draw_object_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             state;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [X_W-1:0]     x_arr [N_REQ];
    logic [Y_W-1:0]     y_arr [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            x_arr[i] = req_x[i*X_W +: X_W];
            y_arr[i] = req_y[i*Y_W +: Y_W];
        end
    end

    rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req   (req),
        .last  (last_q),
        .valid (sel_valid),
        .idx   (sel_idx)
    );

    // Timeout is a down-counter loaded in LOAD; reaching zero in BUSY means
    // TIMEOUT_CYCLES BUSY cycles have elapsed. Engine done wins a tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            idx_q       <= '0;
            last_q      <= IDX_W'(N_REQ - 1);
            tmo_cnt     <= '0;
            grant       <= '0;
            done        <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            draw_start  <= 1'b0;
            draw_erase  <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        state      <= ST_LOAD;
                        idx_q      <= sel_idx;
                        grant      <= N_REQ'(1) << sel_idx;
                        busy       <= 1'b1;
                        draw_erase <= req_erase[sel_idx];
                        draw_x     <= x_arr[sel_idx];
                        draw_y     <= y_arr[sel_idx];
                    end
                end
                ST_LOAD: begin
                    state      <= ST_BUSY;
                    draw_start <= 1'b1;
                    tmo_cnt    <= CNT_W'(TIMEOUT_CYCLES - 1);
                end
                ST_BUSY: begin
                    if (draw_object_done) begin
                        state      <= ST_DONE;
                        draw_start <= 1'b0;
                        done       <= grant;
                    end else if (tmo_cnt == '0) begin
                        state       <= ST_DONE;
                        draw_start  <= 1'b0;
                        done        <= grant;
                        timeout_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    last_q      <= idx_q;
                    grant       <= '0;
                    done        <= '0;
                    busy        <= 1'b0;
                    timeout_err <= 1'b0;
                    draw_erase  <= 1'b0;
                    draw_x      <= '0;
                    draw_y      <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_arbiter.sv
// tb_draw_arbiter
// Directed and randomized bench for draw_arbiter with a short timeout (8).
// The reference model picks winners by scanning requesters from last+1 and
// derives the BUSY length from the engine latency and the timeout.
module tb_draw_arbiter;

    localparam int N  = 4;
    localparam int T  = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N-1:0]   req_erase;
    logic [9*N-1:0] req_x;
    logic [8*N-1:0] req_y;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic           timeout_err;
    logic           draw_start;
    logic           draw_erase;
    logic [8:0]     draw_x;
    logic [7:0]     draw_y;
    logic           draw_object_done;

    int n_tests = 0;
    int n_fail  = 0;
    int last_m  = N - 1;

    logic [8:0] xs [N];
    logic [7:0] ys [N];
    logic       es [N];

    draw_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_erase        (req_erase),
        .req_x            (req_x),
        .req_y            (req_y),
        .grant            (grant),
        .done             (done),
        .busy             (busy),
        .timeout_err      (timeout_err),
        .draw_start       (draw_start),
        .draw_erase       (draw_erase),
        .draw_x           (draw_x),
        .draw_y           (draw_y),
        .draw_object_done (draw_object_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            req_x[i*9 +: 9] = xs[i];
            req_y[i*8 +: 8] = ys[i];
            req_erase[i]    = es[i];
        end
    endtask

    task automatic rand_bus();
        for (int i = 0; i < N; i++) begin
            xs[i] = 9'($urandom);
            ys[i] = 8'($urandom);
            es[i] = 1'($urandom);
        end
        drive_bus();
    endtask

    // First requesting index strictly after 'last', wrapping around.
    function automatic int pick(input logic [N-1:0] rq, input int last);
        for (int k = 1; k <= N; k++) begin
            if (rq[(last + k) % N]) return (last + k) % N;
        end
        return 0;
    endfunction

    // One complete service, starting and ending at a negedge in IDLE.
    // lat: engine asserts draw_object_done in its lat-th BUSY cycle.
    task automatic service(input logic [N-1:0] rq, input int lat,
                           input bit withdraw, input bit spur);
        int         w;
        int         nbusy;
        bit         abort;
        logic [N-1:0] g_exp;
        logic [8:0] ex;
        logic [7:0] ey;
        logic       ee;
        w     = pick(rq, last_m);
        g_exp = N'(1) << w;
        ex    = xs[w];
        ey    = ys[w];
        ee    = es[w];
        nbusy = (lat <= T) ? lat : T;
        abort = (lat > T);
        req   = rq;
        drive_bus();
        draw_object_done = spur;

        @(posedge clk); @(negedge clk);
        check("load_grant", grant, g_exp);
        check("load_start", draw_start, 0);
        check("load_busy", busy, 1);
        check("load_x", draw_x, ex);
        check("load_y", draw_y, ey);
        check("load_erase", draw_erase, ee);
        check("load_done", done, 0);
        draw_object_done = 1'b0;
        if (withdraw) req = '0;
        ys[w] = ys[w] + 8'd1;
        drive_bus();

        for (int k = 1; k <= nbusy; k++) begin
            @(posedge clk); @(negedge clk);
            check("busy_start", draw_start, 1);
            check("busy_grant", grant, g_exp);
            check("busy_x", draw_x, ex);
            check("busy_y", draw_y, ey);
            check("busy_erase", draw_erase, ee);
            check("busy_done", done, 0);
            draw_object_done = (k == lat);
            rand_bus();
        end

        @(posedge clk); @(negedge clk);
        check("done_pulse", done, g_exp);
        check("done_tmo", timeout_err, abort);
        check("done_start", draw_start, 0);
        check("done_grant", grant, g_exp);
        check("done_busy", busy, 1);
        draw_object_done = spur;
        req = '0;

        @(posedge clk); @(negedge clk);
        check("idle_done", done, 0);
        check("idle_tmo", timeout_err, 0);
        check("idle_busy", busy, 0);
        check("idle_grant", grant, 0);
        check("idle_x", draw_x, 0);
        check("idle_start", draw_start, 0);
        draw_object_done = 1'b0;
        last_m = w;
    endtask

    initial begin
        logic [N-1:0] rq;
        reset = 1'b1;
        req = '0;
        draw_object_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            xs[i] = '0; ys[i] = '0; es[i] = 1'b0;
        end
        drive_bus();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_start", draw_start, 0);
        check("rst_x", draw_x, 0);
        check("rst_tmo", timeout_err, 0);
        reset = 1'b0;
        last_m = N - 1;

        // Spurious engine done while idle.
        draw_object_done = 1'b1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("spur_idle_busy", busy, 0);
            check("spur_idle_done", done, 0);
        end
        draw_object_done = 1'b0;

        // Single request, y changed to 41 during BUSY inside service.
        xs[0] = 9'd160; ys[0] = 8'd40; es[0] = 1'b0;
        service(4'b0001, 5, 1'b0, 1'b1);

        // Rotation with all requesters active.
        for (int r = 0; r < 5; r++) begin
            rand_bus();
            service(4'b1111, $urandom_range(1, 6), 1'b0, 1'b0);
        end

        // Timeout boundary: done on the last allowed cycle, then aborts.
        rand_bus();
        service(4'b0100, T, 1'b0, 1'b0);
        rand_bus();
        service(4'b1000, T + 1, 1'b0, 1'b0);
        rand_bus();
        service(4'b0011, 100, 1'b0, 1'b0);

        // Requester withdraws during service.
        rand_bus();
        service(4'b0010, 3, 1'b1, 1'b0);

        // Randomized services.
        for (int r = 0; r < 40; r++) begin
            rand_bus();
            rq = N'($urandom_range(1, 15));
            service(rq, $urandom_range(1, 11), 1'($urandom), 1'($urandom));
        end

        // Reset asserted mid-BUSY between clock edges.
        rand_bus();
        req = 4'b0100;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        check("pre_rst_start", draw_start, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_start", draw_start, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        req = '0;
        reset = 1'b0;
        last_m = N - 1;
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        rand_bus();
        service(4'b1111, 2, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_arbiter.md
# draw_arbiter

Round-robin arbiter sharing the single hook/object draw engine among up to four requesting control FSMs: release hook, pull-back hook, black line and object renderer. It latches the winning requester's coordinates and erase flag, drives the engine's start/erase/x/y inputs, waits for `draw_object_done`, then pulses a per-requester done. It sits between the per-phase control FSMs and the shared draw datapath, so no two FSMs drive the engine at once.

## Interface
- `N_REQ`, 4: number of requesters; index 0 = release, 1 = pull-back, 2 = black line, 3 = object.
- `TIMEOUT_CYCLES`, 4096: maximum BUSY cycles before a forced abort; range 2..8191.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; forces all state and outputs to reset values.
- `req`  in  N_REQ  level request per requester; held until its `done` bit is seen.
- `req_erase`  in  N_REQ  1 = erase (background colour) draw, 0 = normal draw.
- `req_x`  in  9*N_REQ  packed start x; requester i occupies bits [9i+8:9i].
- `req_y`  in  8*N_REQ  packed start y; requester i occupies bits [8i+7:8i].
- `grant`  out  N_REQ  one-hot; high from LOAD through DONE for the serviced requester.
- `done`  out  N_REQ  one-cycle pulse to the serviced requester in DONE.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  one-cycle pulse in DONE when the service was aborted.
- `draw_start`  out  1  engine start; high for the whole of BUSY.
- `draw_erase`  out  1  latched erase flag; valid LOAD..DONE, else 0.
- `draw_x`  out  9  latched x; valid LOAD..DONE, else 0.
- `draw_y`  out  8  latched y; valid LOAD..DONE, else 0.
- `draw_object_done`  in  1  engine completion; sampled only in BUSY.

## Operation
- States: IDLE, LOAD, BUSY, DONE. Reset → IDLE.
- IDLE: if `req` is nonzero, the selector chooses the first set bit searching upward from `last+1` (mod N_REQ). The winner's index, x, y and erase are latched into internal registers on that edge. Next state is LOAD. If `req` is zero, stay in IDLE.
- LOAD: `grant` asserted, `draw_*` presented and stable, `draw_start` still 0. Unconditional → BUSY. The timeout counter clears.
- BUSY: `draw_start`=1. The timeout counter increments each cycle.
  - If `draw_object_done`=1 → DONE.
  - Otherwise, if the counter reaches `TIMEOUT_CYCLES`-1 → DONE with an abort flag.
- DONE: `draw_start`=0. `done[idx]`=1, and `timeout_err`=1 if aborted. `last` ← idx. Unconditional → IDLE.
- Requesters must drop `req` in the cycle after seeing `done`. A `req` still high in IDLE is treated as a new request.
- Latched values are immune to changes on `req_x`, `req_y` and `req_erase` after the IDLE→LOAD edge.
- If a requester withdraws `req` during LOAD or BUSY, the service still completes and `done` still pulses.
- `draw_object_done` outside BUSY is ignored.
- Reset values: every output 0, state IDLE, counter 0, `last` = N_REQ-1 so requester 0 wins first.
- Reset asserted mid-service: the engine start drops immediately (asynchronous), no `done` pulse is generated, and the arbiter restarts from IDLE.

## Timing
- Request seen in IDLE at cycle n: `grant` at n+1, `draw_start` at n+2.
- `draw_object_done` sampled high at cycle m: DONE at m+1, IDLE at m+2.
- Overhead per service is 3 non-drawing cycles (LOAD, DONE, IDLE). The earliest re-grant follows at m+3.
- Timeout: with no done, DONE occurs `TIMEOUT_CYCLES` cycles after BUSY entry.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,3,0…; worst-case wait is N_REQ-1 services.

## Structure
- Shared package holds:
  - coordinate widths X_W=9 and Y_W=8;
  - requester index constants REQ_RELEASE=0, REQ_PULL=1, REQ_LINE=2, REQ_OBJ=3;
  - state encodings for IDLE, LOAD, BUSY and DONE.
- One combinational sub-module, `rr_select`, with ports `req`, `last`, and outputs `valid`, `idx`. It implements the rotate-and-priority search and is unit-testable on its own.

## Test plan
- Single request: `req`=0001, x=160, y=40, erase=0, engine done 5 cycles after start. Required: `grant`=0001 at n+1, `draw_start` high at n+2 for 5 cycles, `draw_x`=160, `draw_y`=40, `done`=0001 for one cycle, then IDLE.
- Rotation: `req`=1111 held with re-assertion after each `done`. Required: grant order 0,1,2,3,0.
- Latch stability: change `req_y[0]` from 40 to 41 during BUSY. Required: `draw_y` stays 40 until IDLE.
- Timeout: `TIMEOUT_CYCLES`=8, engine never completes. Required: DONE after 8 BUSY cycles, `done[idx]` and `timeout_err` both pulse once.
- Reset mid-BUSY: assert `reset` between clock edges. Required: `draw_start`, `grant` and `busy` go 0 immediately, no `done` pulse; the next request to requester 0 is granted first.
- Spurious done: `draw_object_done`=1 in IDLE and LOAD. Required: no state change beyond the normal LOAD→BUSY transition and no `done` pulse.
